// File: rtl/sa_result_drain.sv
// rtl/sa_result_drain.sv - ping-pong tile buffer draining systolic-array column results to a valid/ready stream
// Optional: define SA_DRAIN_RELU_EN to clamp negative result words to zero at capture.
module sa_result_drain #(
    parameter int ROWS     = 8,
    parameter int OUTWIDTH = 32,
    parameter int TAGW     = 4,
    localparam int CW      = $clog2(ROWS)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [OUTWIDTH-1:0] res_in [0:ROWS-1],
    input  logic [0:ROWS-1]     res_valid,
    output logic                res_read,
    output logic [OUTWIDTH-1:0] m_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                m_last,
    output logic [CW-1:0]       m_col,
    output logic [TAGW-1:0]     m_tile,
    output logic                full,
    output logic [15:0]         stall_cnt
);

    typedef enum logic {IDLE, SEND} state_t;

    logic [OUTWIDTH-1:0] bank_q [2][ROWS];
    logic [TAGW-1:0]     bank_tag_q [2];
    logic [1:0]          bank_full_q, bank_full_d;
    logic                wbank_q, rbank_q, rbank_d;
    logic [TAGW-1:0]     tag_q;
    logic                armed_q, armed_d;
    logic                res_read_q;
    logic [15:0]         stall_q, stall_d;
    state_t              state_q, state_d;
    logic [CW-1:0]       col_q, col_d;

    logic                all_valid, capture, blocked, hs, release_bank;
    logic [OUTWIDTH-1:0] cap_word [ROWS];

    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
`ifdef SA_DRAIN_RELU_EN
            cap_word[i] = res_in[i][OUTWIDTH-1] ? '0 : res_in[i];
`else
            cap_word[i] = res_in[i];
`endif
        end
    end

    always_comb begin
        all_valid    = &res_valid;
        capture      = all_valid && armed_q && !bank_full_q[wbank_q];
        blocked      = all_valid && armed_q && bank_full_q[wbank_q];
        hs           = (state_q == SEND) && m_ready;
        release_bank = hs && (col_q == CW'(ROWS - 1));

        bank_full_d = bank_full_q;
        if (release_bank) bank_full_d[rbank_q] = 1'b0;
        if (capture)      bank_full_d[wbank_q] = 1'b1;

        stall_d = (blocked && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
        armed_d = capture ? 1'b0 : (!all_valid ? 1'b1 : armed_q);

        state_d = state_q;
        col_d   = col_q;
        rbank_d = rbank_q;
        case (state_q)
            IDLE: begin
                // Looking at next-state occupancy lets the first word leave in the res_read cycle.
                if (bank_full_d[rbank_q]) begin
                    state_d = SEND;
                    col_d   = '0;
                end
            end
            SEND: begin
                if (release_bank) begin
                    col_d   = '0;
                    rbank_d = ~rbank_q;
                    state_d = bank_full_d[~rbank_q] ? SEND : IDLE;
                end else if (hs) begin
                    col_d = col_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            bank_tag_q  <= '{default: '0};
            bank_full_q <= '0;
            wbank_q     <= 1'b0;
            rbank_q     <= 1'b0;
            tag_q       <= '0;
            armed_q     <= 1'b1;
            res_read_q  <= 1'b0;
            stall_q     <= '0;
            state_q     <= IDLE;
            col_q       <= '0;
        end else begin
            if (capture) begin
                bank_tag_q[wbank_q] <= tag_q;
                wbank_q             <= ~wbank_q;
                tag_q               <= tag_q + TAGW'(1);
            end
            bank_full_q <= bank_full_d;
            rbank_q     <= rbank_d;
            armed_q     <= armed_d;
            res_read_q  <= capture;
            stall_q     <= stall_d;
            state_q     <= state_d;
            col_q       <= col_d;
        end
    end

    // Result words need no reset: they are only visible once their bank is marked full.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < ROWS; i++) bank_q[wbank_q][i] <= cap_word[i];
        end
    end

    assign res_read  = res_read_q;
    assign m_valid   = (state_q == SEND);
    assign m_data    = bank_q[rbank_q][col_q];
    assign m_col     = col_q;
    assign m_tile    = bank_tag_q[rbank_q];
    assign m_last    = m_valid && (col_q == CW'(ROWS - 1));
    assign full      = &bank_full_q;
    assign stall_cnt = stall_q;

endmodule

// File: doc/sa_result_drain.md
Name: sa_result_drain

Overview:
- Downstream stage of the systolic-array core. Consumes the per-column result bus and per-column valid flags.
- Snapshots a complete tile (ROWS column results) into one of two ping-pong banks, then pulses the core's "outputs read" input.
- Streams buffered results out one word per cycle over a valid/ready interface, tagged with column index and tile number.
- Decouples the array's bursty output from a slower memory/DMA consumer.

Parameters:
- ROWS, 8, number of columns/result words per tile; power of two, >=2
- OUTWIDTH, 32, result word width (two's complement)
- TAGW, 4, tile tag counter width

Ports:
- clk  input  1  clock
- rstn  input  1  reset, synchronous, active-low
- res_in  input  OUTWIDTH x [0:ROWS-1] unpacked  column results from core
- res_valid  input  ROWS (packed [0:ROWS-1])  per-column result valid from core
- res_read  output  1  one-cycle pulse: tile consumed; drives core outread
- m_data  output  OUTWIDTH  streamed result word
- m_valid  output  1  m_data valid
- m_ready  input  1  consumer accept
- m_last  output  1  high with last word (column ROWS-1) of a tile
- m_col  output  $clog2(ROWS)  column index of m_data
- m_tile  output  TAGW  tag of tile being streamed
- full  output  1  both banks occupied
- stall_cnt  output  16  cycles a complete tile waited because both banks were full; saturates at 0xFFFF

Behaviour:
- Reset (rstn low at posedge): res_read=0, m_valid=0, m_last=0, m_col=0, m_tile=0, full=0, stall_cnt=0. Both banks empty; wbank=rbank=0; tag=0; armed=1. Reset mid-stream discards buffered data; no further handshakes until new capture.
- Storage: 2 banks x ROWS x OUTWIDTH registers plus a per-bank TAGW tag and a bank_full bit per bank.
- Capture condition: res_valid all ones AND armed AND bank_full[wbank]==0.
- On capture (posedge):
  - res_in[0..ROWS-1] written into bank wbank; bank tag = tag.
  - bank_full[wbank] set; wbank toggles; tag increments, wrapping at 2^TAGW.
  - armed cleared; res_read=1 in the following cycle only (registered, exactly 1 cycle).
- Re-arm: armed set at any posedge where res_valid != all ones. This prevents double capture while the core still shows stale valids after res_read.
- Full: capture condition blocked by bank_full[wbank] and res_valid all ones with armed: stall_cnt+=1 (saturating), no res_read, core holds outputs. Capture proceeds the cycle after a bank frees.
- Stream FSM states:
  - IDLE: m_valid=0. Go to SEND when bank_full[rbank]=1; col=0.
  - SEND: m_valid=1, m_data=bank[rbank][col], m_col=col, m_tile=tag[rbank], m_last=(col==ROWS-1).
    - m_valid and m_ready: col+1.
    - Handshake with m_last: bank_full[rbank] cleared, rbank toggles, col=0. Stay in SEND if the other bank is full (back-to-back, no bubble), else IDLE.
    - m_ready low: m_data, m_col, m_tile, m_last held stable; m_valid never drops before handshake.
- Outputs are registered. First word appears 1 cycle after capture (m_valid high in the same cycle as res_read). Steady state: 1 word/cycle with m_ready held high.
- Simultaneous capture into one bank and release of the other bank in the same cycle: both take effect.
- full = bank_full[0] & bank_full[1].

Optional Feature:
- Macro: SA_DRAIN_RELU_EN
- Defined: at capture, each res_in word with MSB=1 is stored as 0 (ReLU); non-negative words stored unchanged.
- Undefined: words stored bit-exact. Everything else identical.

Test Plan:
- ROWS=4, res_in={10,-3,7,0x7FFFFFFF}, res_valid=4'b1111 for 1 cycle, m_ready=1 -> res_read pulses 1 cycle; words 10,-3,7,0x7FFFFFFF with m_col 0..3; m_last on col 3; m_tile=0. With SA_DRAIN_RELU_EN defined: -3 streams as 0.
- res_valid held all ones for 5 cycles, then dropped 1 cycle and raised again -> exactly two captures, two res_read pulses, tags 0 then 1.
- m_ready=0 for 10 cycles, three tiles presented -> two captures, full=1; third tile stalls with stall_cnt=8 after 8 waiting cycles; m_data/m_col stable. On m_ready=1, third tile captured the cycle after the first bank frees.
- m_ready=1, tiles arriving every 4 cycles -> continuous 1 word/cycle with no bubble between m_last and next col 0; tag wraps 15->0 on the 17th tile (TAGW=4).
- m_ready toggling 1,0,1,0 -> each word emitted exactly once, in order; m_valid never deasserts mid-tile.
- Assert rstn=0 during col 2 of a tile -> next cycle m_valid=0, full=0, stall_cnt=0; next tile streams with m_tile=0.
